iir_deemph: RTL and testbench

IIR_DEEMPH -- requirements
Module: iir_deemph

---
 rtl/iir_deemph.sv | 142 ++++++++++++++
 tb/tb_iir_deemph.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_deemph.sv
// iir_deemph: fixed-point IIR filter between two FIFOs. It is used for
// de-emphasis.
//
// One sample is handled at a time by a five-state sequencer:
//   IDLE -> READ -> MULT -> ACC -> (WRITE) -> IDLE
// For each input sample the output is
//   y[n] = (sum X_COEFFS[i]*x[n-i] + sum_{i>=1} Y_COEFFS[i]*y[n-i]) >>> BITS
// One output is pushed for every DECIMATION input samples.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   rd_fifo_empty      upstream FIFO has no sample
//   rd_fifo_rd_en      pop upstream FIFO (combinational, READ state)
//   rd_fifo_data_in    upstream head sample (first-word fall-through)
//   wr_fifo_full       downstream FIFO cannot accept
//   wr_fifo_wr_en      push downstream FIFO (combinational, WRITE state)
//   wr_fifo_data_out   filtered sample, held stable while in WRITE
module iir_deemph #(
    parameter int DECIMATION      = 1,
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int NUM_TAPS        = 2,
    parameter int BITS            = 10,
    parameter logic signed [31:0] X_COEFFS [NUM_TAPS] = '{default: '0},
    parameter logic signed [31:0] Y_COEFFS [NUM_TAPS] = '{default: '0}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_fifo_empty,
    output logic                       rd_fifo_rd_en,
    input  logic [FIFO_DATA_WIDTH-1:0] rd_fifo_data_in,
    input  logic                       wr_fifo_full,
    output logic                       wr_fifo_wr_en,
    output logic [FIFO_DATA_WIDTH-1:0] wr_fifo_data_out
);

    localparam int PW = FIFO_DATA_WIDTH + 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MULT,
        S_ACC,
        S_WRITE
    } state_t;

    state_t state, state_nxt;

    // x_hist[0] holds x[n]. y_hist[0] holds the most recent output y[n-1]
    // while the products for sample n are formed.
    logic signed [FIFO_DATA_WIDTH-1:0] x_hist [NUM_TAPS];
    logic signed [FIFO_DATA_WIDTH-1:0] y_hist [NUM_TAPS];
    logic signed [PW-1:0]              x_prod [NUM_TAPS];
    logic signed [PW-1:0]              y_prod [NUM_TAPS];
    logic [3:0]                        dec_cnt;
    logic signed [63:0]                acc_sum;
    logic signed [63:0]                acc_shr;
    logic                              dec_done;

    // 64-bit accumulation. It wraps silently on overflow. y_prod[0] is held
    // at zero, so Y_COEFFS[0] has no effect.
    always_comb begin
        acc_sum = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            acc_sum = acc_sum + 64'(x_prod[i]) + 64'(y_prod[i]);
        end
        acc_shr  = acc_sum >>> BITS;
        dec_done = (dec_cnt == 4'(DECIMATION - 1));
    end

    always_comb begin
        state_nxt     = state;
        rd_fifo_rd_en = 1'b0;
        wr_fifo_wr_en = 1'b0;
        case (state)
            S_IDLE:  if (!rd_fifo_empty) state_nxt = S_READ;
            S_READ: begin
                if (!rd_fifo_empty) begin
                    rd_fifo_rd_en = 1'b1;
                    state_nxt     = S_MULT;
                end
            end
            S_MULT:  state_nxt = S_ACC;
            S_ACC:   state_nxt = dec_done ? S_WRITE : S_IDLE;
            S_WRITE: begin
                if (!wr_fifo_full) begin
                    wr_fifo_wr_en = 1'b1;
                    state_nxt     = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            dec_cnt          <= '0;
            wr_fifo_data_out <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                x_hist[i] <= '0;
                y_hist[i] <= '0;
                x_prod[i] <= '0;
                y_prod[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                S_READ: begin
                    if (!rd_fifo_empty) begin
                        for (int i = NUM_TAPS - 1; i > 0; i--) x_hist[i] <= x_hist[i-1];
                        x_hist[0] <= rd_fifo_data_in;
                    end
                end
                S_MULT: begin
                    // The size casts keep the operands signed. The product
                    // therefore holds the full signed result.
                    for (int i = 0; i < NUM_TAPS; i++) begin
                        x_prod[i] <= PW'(x_hist[i]) * PW'(X_COEFFS[i]);
                    end
                    y_prod[0] <= '0;
                    for (int i = 1; i < NUM_TAPS; i++) begin
                        y_prod[i] <= PW'(y_hist[i-1]) * PW'(Y_COEFFS[i]);
                    end
                end
                S_ACC: begin
                    // The feedback history advances on every sample.
                    // Decimation only gates the output write.
                    for (int i = NUM_TAPS - 1; i > 0; i--) y_hist[i] <= y_hist[i-1];
                    y_hist[0] <= acc_shr[FIFO_DATA_WIDTH-1:0];
                    if (dec_done) begin
                        dec_cnt          <= '0;
                        wr_fifo_data_out <= acc_shr[FIFO_DATA_WIDTH-1:0];
                    end else begin
                        dec_cnt <= dec_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_deemph.sv
// tb_iir_deemph: self-checking bench for iir_deemph.
// Five instances run side by side, each with different coefficients or
// decimation. Each has an array-modelled upstream FIFO and a capture log
// of its writes. Expected outputs come from a plain-arithmetic model of
// the filter equation.
module tb_iir_deemph;

    localparam int N = 5;
    localparam int DEPTH = 256;
    localparam int XC [N][2] = '{'{1024, 0}, '{1024, 0}, '{1024, 0}, '{512, 0}, '{700, -300}};
    localparam int YC [N][2] = '{'{0, 0}, '{0, 512}, '{0, 0}, '{0, 0}, '{999, 400}};
    localparam int DEC [N]   = '{1, 1, 2, 1, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        empty [N];
    logic        rd_en [N];
    logic [31:0] din   [N];
    logic        full  [N];
    logic        wr_en [N];
    logic [31:0] dout  [N];

    logic signed [31:0] in_mem  [N][DEPTH];
    int                 in_wr   [N];
    int                 in_rd   [N];
    logic signed [31:0] out_mem [N][DEPTH];
    int                 out_cnt [N];
    int                 rd_cyc  [N][DEPTH];
    int                 wr_cyc  [N][DEPTH];
    int                 cyc;
    int                 both_cnt;

    // reference model state
    logic signed [31:0] mx [N][2];
    logic signed [31:0] my [N][2];
    int                 mcnt [N];
    logic signed [31:0] exp_mem [N][DEPTH];
    int                 exp_cnt [N];

    int nchk = 0;
    int npass = 0;

    always #5 clk = ~clk;

    iir_deemph #(.DECIMATION(1), .X_COEFFS('{32'sd1024, 32'sd0}), .Y_COEFFS('{32'sd0, 32'sd0})) u0 (
        .clk(clk), .rst(rst), .rd_fifo_empty(empty[0]), .rd_fifo_rd_en(rd_en[0]),
        .rd_fifo_data_in(din[0]), .wr_fifo_full(full[0]), .wr_fifo_wr_en(wr_en[0]),
        .wr_fifo_data_out(dout[0]));
    iir_deemph #(.DECIMATION(1), .X_COEFFS('{32'sd1024, 32'sd0}), .Y_COEFFS('{32'sd0, 32'sd512})) u1 (
        .clk(clk), .rst(rst), .rd_fifo_empty(empty[1]), .rd_fifo_rd_en(rd_en[1]),
        .rd_fifo_data_in(din[1]), .wr_fifo_full(full[1]), .wr_fifo_wr_en(wr_en[1]),
        .wr_fifo_data_out(dout[1]));
    iir_deemph #(.DECIMATION(2), .X_COEFFS('{32'sd1024, 32'sd0}), .Y_COEFFS('{32'sd0, 32'sd0})) u2 (
        .clk(clk), .rst(rst), .rd_fifo_empty(empty[2]), .rd_fifo_rd_en(rd_en[2]),
        .rd_fifo_data_in(din[2]), .wr_fifo_full(full[2]), .wr_fifo_wr_en(wr_en[2]),
        .wr_fifo_data_out(dout[2]));
    iir_deemph #(.DECIMATION(1), .X_COEFFS('{32'sd512, 32'sd0}), .Y_COEFFS('{32'sd0, 32'sd0})) u3 (
        .clk(clk), .rst(rst), .rd_fifo_empty(empty[3]), .rd_fifo_rd_en(rd_en[3]),
        .rd_fifo_data_in(din[3]), .wr_fifo_full(full[3]), .wr_fifo_wr_en(wr_en[3]),
        .wr_fifo_data_out(dout[3]));
    iir_deemph #(.DECIMATION(1), .X_COEFFS('{32'sd700, -32'sd300}), .Y_COEFFS('{32'sd999, 32'sd400})) u4 (
        .clk(clk), .rst(rst), .rd_fifo_empty(empty[4]), .rd_fifo_rd_en(rd_en[4]),
        .rd_fifo_data_in(din[4]), .wr_fifo_full(full[4]), .wr_fifo_wr_en(wr_en[4]),
        .wr_fifo_data_out(dout[4]));

    for (genvar g = 0; g < N; g++) begin : g_fifo
        assign empty[g] = (in_rd[g] == in_wr[g]);
        assign din[g]   = in_mem[g][in_rd[g] % DEPTH];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < N; k++) begin
            if (rd_en[k]) begin
                rd_cyc[k][in_rd[k]] <= cyc;
                in_rd[k]            <= in_rd[k] + 1;
            end
            if (wr_en[k]) begin
                out_mem[k][out_cnt[k]] <= dout[k];
                wr_cyc[k][out_cnt[k]]  <= cyc;
                out_cnt[k]             <= out_cnt[k] + 1;
            end
            if (rd_en[k] && wr_en[k]) both_cnt <= both_cnt + 1;
        end
    end

    // Model: direct evaluation of the difference equation with 64-bit wrap,
    // floor shift and truncation to 32 bits; decimation picks every DEC-th y.
    function automatic void model_feed(int k, logic signed [31:0] x);
        longint acc;
        logic signed [31:0] y;
        mx[k][1] = mx[k][0];
        mx[k][0] = x;
        acc = longint'(mx[k][0]) * longint'(XC[k][0]) + longint'(mx[k][1]) * longint'(XC[k][1])
            + longint'(my[k][0]) * longint'(YC[k][1]);
        acc = acc >>> 10;
        y = acc[31:0];
        my[k][1] = my[k][0];
        my[k][0] = y;
        mcnt[k]++;
        if (mcnt[k] == DEC[k]) begin
            mcnt[k] = 0;
            exp_mem[k][exp_cnt[k]] = y;
            exp_cnt[k]++;
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            mx[k][0] = 0; mx[k][1] = 0; my[k][0] = 0; my[k][1] = 0;
            mcnt[k] = 0;
            exp_cnt[k] = out_cnt[k];
        end
    endfunction

    task automatic push(int k, logic signed [31:0] v);
        in_mem[k][in_wr[k] % DEPTH] = v;
        in_wr[k]++;
    endtask

    task automatic feed(int k, logic signed [31:0] v);
        push(k, v);
        model_feed(k, v);
    endtask

    task automatic wait_out(int k, int target);
        for (int i = 0; i < 3000 && out_cnt[k] < target; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            nchk++;
            if (rd_en[k] !== 1'b0 || wr_en[k] !== 1'b0 || dout[k] !== 32'd0)
                $display("FAIL reset_state inst%0d: rd_en=%b wr_en=%b dout=%0d, want 0/0/0",
                         k, rd_en[k], wr_en[k], dout[k]);
            else npass++;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_identity();
        int ob = out_cnt[0];
        int rb = in_rd[0];
        feed(0, 5);
        feed(0, -7);
        wait_out(0, ob + 2);
        nchk++;
        if (out_cnt[0] !== ob + 2) $display("FAIL identity_count: got %0d writes, want %0d", out_cnt[0] - ob, 2);
        else npass++;
        nchk++;
        if ($signed(out_mem[0][ob]) !== 32'sd5) $display("FAIL identity_v0: got %0d, want 5", $signed(out_mem[0][ob]));
        else npass++;
        nchk++;
        if ($signed(out_mem[0][ob+1]) !== -32'sd7) $display("FAIL identity_v1: got %0d, want -7", $signed(out_mem[0][ob+1]));
        else npass++;
        for (int j = 0; j < 2; j++) begin
            nchk++;
            if (wr_cyc[0][ob+j] - rd_cyc[0][rb+j] !== 3)
                $display("FAIL identity_latency%0d: got %0d cycles, want 3", j, wr_cyc[0][ob+j] - rd_cyc[0][rb+j]);
            else npass++;
        end
        for (int j = 0; j < 12; j++) feed(0, $urandom);
        wait_out(0, ob + 14);
        for (int j = ob; j < exp_cnt[0]; j++) begin
            nchk++;
            if (out_mem[0][j] !== exp_mem[0][j])
                $display("FAIL identity_rand%0d: got %0d, want %0d", j, $signed(out_mem[0][j]), $signed(exp_mem[0][j]));
            else npass++;
        end
    endtask

    task automatic test_feedback();
        int ob = out_cnt[1];
        int want [4] = '{1024, 512, 256, 128};
        feed(1, 1024); feed(1, 0); feed(1, 0); feed(1, 0);
        wait_out(1, ob + 4);
        for (int j = 0; j < 4; j++) begin
            nchk++;
            if ($signed(out_mem[1][ob+j]) !== want[j] || out_mem[1][ob+j] !== exp_mem[1][ob+j])
                $display("FAIL feedback_v%0d: got %0d, want %0d", j, $signed(out_mem[1][ob+j]), want[j]);
            else npass++;
        end
    endtask

    task automatic test_decimation();
        int ob = out_cnt[2];
        int rb = in_rd[2];
        feed(2, 1); feed(2, 2); feed(2, 3); feed(2, 4);
        wait_out(2, ob + 2);
        repeat (20) @(negedge clk);
        nchk++;
        if (out_cnt[2] - ob !== 2 || in_rd[2] - rb !== 4)
            $display("FAIL decim_counts: got %0d writes %0d reads, want 2 writes 4 reads", out_cnt[2] - ob, in_rd[2] - rb);
        else npass++;
        nchk++;
        if ($signed(out_mem[2][ob]) !== 32'sd2 || $signed(out_mem[2][ob+1]) !== 32'sd4)
            $display("FAIL decim_values: got %0d,%0d, want 2,4", $signed(out_mem[2][ob]), $signed(out_mem[2][ob+1]));
        else npass++;
        for (int j = 0; j < 10; j++) feed(2, $urandom);
        wait_out(2, ob + 7);
        for (int j = ob + 2; j < exp_cnt[2]; j++) begin
            nchk++;
            if (out_mem[2][j] !== exp_mem[2][j])
                $display("FAIL decim_rand%0d: got %0d, want %0d", j, $signed(out_mem[2][j]), $signed(exp_mem[2][j]));
            else npass++;
        end
    endtask

    task automatic test_rounding();
        int ob = out_cnt[3];
        feed(3, -3);
        feed(3, 3);
        wait_out(3, ob + 2);
        nchk++;
        if ($signed(out_mem[3][ob]) !== -32'sd2) $display("FAIL round_neg: got %0d, want -2", $signed(out_mem[3][ob]));
        else npass++;
        nchk++;
        if ($signed(out_mem[3][ob+1]) !== 32'sd1) $display("FAIL round_pos: got %0d, want 1", $signed(out_mem[3][ob+1]));
        else npass++;
        for (int j = 0; j < 8; j++) feed(3, $urandom);
        wait_out(3, ob + 10);
        for (int j = ob + 2; j < exp_cnt[3]; j++) begin
            nchk++;
            if (out_mem[3][j] !== exp_mem[3][j])
                $display("FAIL round_rand%0d: got %0d, want %0d", j, $signed(out_mem[3][j]), $signed(exp_mem[3][j]));
            else npass++;
        end
    endtask

    task automatic test_backpressure();
        int ob = out_cnt[4];
        int rb = in_rd[4];
        int bad_wr = 0, bad_dat = 0, bad_rd = 0, bad_idle = 0;
        int i;
        full[4] = 1'b1;
        feed(4, $urandom);
        feed(4, $urandom);
        for (i = 0; i < 100 && in_rd[4] == rb; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            if (wr_en[4] !== 1'b0) bad_wr++;
            if (dout[4] !== exp_mem[4][ob]) bad_dat++;
            if (in_rd[4] !== rb + 1 || rd_en[4] !== 1'b0) bad_rd++;
            @(negedge clk);
        end
        nchk++;
        if (bad_wr != 0) $display("FAIL stall_wr_en: wr_en high in %0d stalled cycles, want 0", bad_wr);
        else npass++;
        nchk++;
        if (bad_dat != 0) $display("FAIL stall_data: dout=%0d unstable in %0d cycles, want %0d", $signed(dout[4]), bad_dat, $signed(exp_mem[4][ob]));
        else npass++;
        nchk++;
        if (bad_rd != 0) $display("FAIL stall_reads: reads=%0d during stall, want %0d", in_rd[4] - rb, 1);
        else npass++;
        full[4] = 1'b0;
        wait_out(4, ob + 2);
        for (int j = ob; j < ob + 2; j++) begin
            nchk++;
            if (out_mem[4][j] !== exp_mem[4][j])
                $display("FAIL bp_value%0d: got %0d, want %0d", j, $signed(out_mem[4][j]), $signed(exp_mem[4][j]));
            else npass++;
        end
        // upstream runs dry: nothing may be read or written
        repeat (4) @(negedge clk);
        ob = out_cnt[4];
        for (int c = 0; c < 20; c++) begin
            if (rd_en[4] !== 1'b0 || wr_en[4] !== 1'b0) bad_idle++;
            @(negedge clk);
        end
        nchk++;
        if (bad_idle != 0 || out_cnt[4] !== ob)
            $display("FAIL starve: %0d active cycles, %0d writes while empty, want 0/0", bad_idle, out_cnt[4] - ob);
        else npass++;
        // random stream with random backpressure
        for (int j = 0; j < 20; j++) feed(4, $urandom);
        for (i = 0; i < 3000 && out_cnt[4] < ob + 20; i++) begin
            full[4] = $urandom_range(0, 1) == 1;
            @(negedge clk);
        end
        full[4] = 1'b0;
        wait_out(4, ob + 20);
        nchk++;
        if (out_cnt[4] !== ob + 20) $display("FAIL bp_rand_count: got %0d writes, want 20", out_cnt[4] - ob);
        else npass++;
        for (int j = ob; j < exp_cnt[4]; j++) begin
            nchk++;
            if (out_mem[4][j] !== exp_mem[4][j])
                $display("FAIL bp_rand%0d: got %0d, want %0d", j, $signed(out_mem[4][j]), $signed(exp_mem[4][j]));
            else npass++;
        end
    endtask

    task automatic test_exclusive();
        nchk++;
        if (both_cnt !== 0) $display("FAIL rd_wr_same_cycle: got %0d cycles, want 0", both_cnt);
        else npass++;
    endtask

    task automatic test_reset_midop();
        int ob = out_cnt[1];
        int i;
        push(1, 1024);
        for (i = 0; i < 100 && rd_en[1] !== 1'b1; i++) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        nchk++;
        if (dout[1] !== 32'd0 || wr_en[1] !== 1'b0 || rd_en[1] !== 1'b0)
            $display("FAIL midop_reset: dout=%0d wr_en=%b rd_en=%b, want 0/0/0", $signed(dout[1]), wr_en[1], rd_en[1]);
        else npass++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (20) @(negedge clk);
        nchk++;
        if (out_cnt[1] !== ob) $display("FAIL midop_discard: got %0d writes, want 0", out_cnt[1] - ob);
        else npass++;
    endtask

    initial begin
        for (int k = 0; k < N; k++) full[k] = 1'b0;
        model_reset();
        test_reset();
        test_identity();
        test_feedback();
        test_decimation();
        test_rounding();
        test_backpressure();
        test_reset_midop();
        test_feedback();
        test_exclusive();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation exceeded its time bound");
        $fatal(1, "timeout");
    end

endmodule
